// File: rtl/pinwheel_bus_pkg.sv
// pinwheel_bus_pkg: region tags, debug register offsets and console status bit positions for the pinwheel data bus
package pinwheel_bus_pkg;
  typedef enum logic [3:0] {
    TAG_CODE  = 4'h0,
    TAG_DATA  = 4'h8,
    TAG_REGS  = 4'hE,
    TAG_DEBUG = 4'hF
  } region_e;
  typedef enum logic [5:0] {
    OFF_CONSOLE    = 6'h00,
    OFF_TICKS      = 6'h01,
    OFF_TEST       = 6'h02,
    OFF_SCRATCH    = 6'h03,
    OFF_FAULT_ADDR = 6'h04,
    OFF_FAULT_CLR  = 6'h05
  } dbg_off_e;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_COUNT = 16;
endpackage

// File: rtl/pinwheel_console_fifo.sv
// pinwheel_console_fifo: byte FIFO feeding the debug console, with sticky overflow on dropped pushes
module pinwheel_console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  input  logic        ovf_clr,
  output logic [7:0]  head,
  output logic        valid,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [15:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop_ok, push_ok;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign valid    = ~empty;
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign head     = mem_q[rd_q];
  assign overflow = ovf_q;
  assign count    = 16'(cnt_q);
  // next-state: a pop frees a slot for a same-cycle push; a dropped push wins over a same-cycle clear
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push_ok ? push_data : mem_q[wr_q];
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    ovf_d = (ovf_q & ~ovf_clr) | (push & ~push_ok);
  end
  // state registers, storage cleared so the head byte reads 0 out of reset
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/pinwheel_data_responder.sv
// pinwheel_data_responder: data RAM at 0x8xxxxxxx and debug registers at 0xFxxxxxxx; PINWHEEL_BUS_FAULT_EN adds unmapped-access fault capture
module pinwheel_data_responder
  import pinwheel_bus_pkg::*;
#(
  parameter int DATA_WORDS    = 16384,
  parameter int CONSOLE_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic [31:0] bus_addr,
  input  logic        bus_rden,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wren,
  output logic [31:0] bus_rdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [31:0] test_status,
`ifdef PINWHEEL_BUS_FAULT_EN
  output logic        bus_fault,
`endif
  output logic        test_done
);
  localparam int IW = $clog2(DATA_WORDS);
  logic [31:0] mem [DATA_WORDS];
  logic [31:0] rdata_q, rdata_d, ticks_q, ticks_d, test_q, test_d, scratch_q, scratch_d;
  logic done_q, done_d;
  logic [31:0] shifted, merged, dbg_rd, status;
  logic [IW-1:0] idx;
  logic [5:0] off;
  logic is_ram, is_dbg, dbg_wr, fifo_push, fifo_clr, fifo_full, fifo_empty, fifo_ovf;
  logic [15:0] fifo_count;
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, new_w, input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
  assign is_ram    = bus_addr[31:28] == TAG_DATA;
  assign is_dbg    = bus_addr[31:28] == TAG_DEBUG;
  assign idx       = bus_addr[2+:IW];
  assign off       = bus_addr[7:2];
  assign shifted   = bus_wdata << {bus_addr[1:0], 3'b000};
  assign dbg_wr    = bus_wren & is_dbg;
  assign merged    = lane_merge(off == OFF_TEST ? test_q : scratch_q, shifted, bus_wmask);
  assign fifo_push = dbg_wr & (off == OFF_CONSOLE) & bus_wmask[0];
  assign fifo_clr  = dbg_wr & (off == OFF_CONSOLE) & bus_wdata[31] & bus_wmask[3];
  pinwheel_console_fifo #(.DEPTH(CONSOLE_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_in  (reset_in),
    .push      (fifo_push),
    .push_data (shifted[7:0]),
    .pop       (console_ready),
    .ovf_clr   (fifo_clr),
    .head      (console_data),
    .valid     (console_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .count     (fifo_count)
  );
`ifdef PINWHEEL_BUS_FAULT_EN
  logic fault_q, fault_d, bad;
  logic [31:0] fault_addr_q, fault_addr_d;
  assign bad = (bus_rden | bus_wren) & ((is_dbg & (off > OFF_FAULT_CLR)) |
               ~(is_ram | is_dbg | bus_addr[31:28] == TAG_CODE | bus_addr[31:28] == TAG_REGS));
  assign bus_fault = fault_q;
  // fault flag is sticky and only the first offending address is kept until cleared
  always_comb begin
    fault_d      = fault_q ? ~(dbg_wr & (off == OFF_FAULT_CLR)) : bad;
    fault_addr_d = (~fault_q & bad) ? bus_addr : fault_addr_q;
  end
  // fault registers
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^bus_addr;
`endif
  // CONSOLE status word and debug read mux, both reflecting pre-write state
  always_comb begin
    status = '0;
    status[ST_COUNT+:16] = fifo_count;
    status[ST_OVF]   = fifo_ovf;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    case (off)
      OFF_CONSOLE:    dbg_rd = status;
      OFF_TICKS:      dbg_rd = ticks_q;
      OFF_TEST:       dbg_rd = test_q;
      OFF_SCRATCH:    dbg_rd = scratch_q;
`ifdef PINWHEEL_BUS_FAULT_EN
      OFF_FAULT_ADDR: dbg_rd = fault_addr_q;
`endif
      default:        dbg_rd = '0;
    endcase
  end
  // read data holds between reads; debug writes merge byte lanes into TEST/SCRATCH
  always_comb begin
    rdata_d   = bus_rden ? (is_ram ? mem[idx] : is_dbg ? dbg_rd : '0) : rdata_q;
    ticks_d   = ticks_q + 32'd1;
    test_d    = (dbg_wr && off == OFF_TEST) ? merged : test_q;
    done_d    = done_q | (dbg_wr && off == OFF_TEST && merged != '0);
    scratch_d = (dbg_wr && off == OFF_SCRATCH) ? merged : scratch_q;
  end
  // bus-side registers
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rdata_q   <= '0;
      ticks_q   <= '0;
      test_q    <= '0;
      done_q    <= 1'b0;
      scratch_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      ticks_q   <= ticks_d;
      test_q    <= test_d;
      done_q    <= done_d;
      scratch_q <= scratch_d;
    end
  end
  // data RAM keeps its contents across reset
  always_ff @(posedge clock) begin
    if (bus_wren & is_ram) mem[idx] <= lane_merge(mem[idx], shifted, bus_wmask);
  end
  assign bus_rdata   = rdata_q;
  assign test_status = test_q;
  assign test_done   = done_q;
endmodule

// File: tb/tb_pinwheel_data_responder.sv
// tb_pinwheel_data_responder: scoreboard bench with a behavioural model of the RAM, console queue and debug registers
module tb_pinwheel_data_responder;
  localparam int DW = 16384;
  localparam int CD = 8;
  logic clock = 0, reset_in = 0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0] bus_wmask = '0;
  logic bus_rden = 0, bus_wren = 0, console_ready = 0;
  logic [31:0] bus_rdata, test_status;
  logic [7:0] console_data;
  logic console_valid, test_done;
`ifdef PINWHEEL_BUS_FAULT_EN
  logic bus_fault;
`endif
  always #5 clock = ~clock;
  pinwheel_data_responder dut (
    .clock(clock), .reset_in(reset_in), .bus_addr(bus_addr), .bus_rden(bus_rden),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_wren(bus_wren), .bus_rdata(bus_rdata),
    .console_data(console_data), .console_valid(console_valid), .console_ready(console_ready),
    .test_status(test_status),
`ifdef PINWHEEL_BUS_FAULT_EN
    .bus_fault(bus_fault),
`endif
    .test_done(test_done)
  );
  logic [31:0] m_ram [int];
  logic [7:0] mq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] m_test, m_scr, m_faddr, m_tick, last_rd;
  logic m_ovf, m_done, m_fault;
  bit rd_fired, in_reset;
  int passed = 0, total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [31:0] lanes(input logic [31:0] old, wd, input logic [1:0] bo, input logic [3:0] m);
    logic [31:0] sh, bm;
    sh = wd << (8*bo);
    bm = '0;
    for (int i = 0; i < 4; i++) if (m[i]) bm |= 32'hFF << (8*i);
    return (old & ~bm) | (sh & bm);
  endfunction
  task automatic clear_model();
    mq.delete(); exp_rd.delete();
    m_test = '0; m_scr = '0; m_faddr = '0; m_tick = '0; last_rd = '0;
    m_ovf = 0; m_done = 0; m_fault = 0; rd_fired = 0;
  endtask
  task automatic model(input bit rd, wr, input logic [31:0] a, wd, input logic [3:0] m);
    logic [3:0] rg; logic [5:0] off; int wi; logic [31:0] rv, sh; bit bad;
    rg = a[31:28]; off = a[7:2]; wi = int'((a >> 2) % DW); rv = '0;
    sh = wd << (8*a[1:0]);
    if (rg == 4'h8) rv = m_ram.exists(wi) ? m_ram[wi] : 'x;
    else if (rg == 4'hF)
      case (off)
        0: rv = {16'(mq.size()), 13'b0, m_ovf, mq.size() == CD, mq.size() == 0};
        1: rv = m_tick;
        2: rv = m_test;
        3: rv = m_scr;
`ifdef PINWHEEL_BUS_FAULT_EN
        4: rv = m_faddr;
`endif
        default: rv = '0;
      endcase
    if (rd) begin exp_rd.push_back(rv); rd_fired = 1; end
    bad = (rd || wr) && ((rg == 4'hF && off > 5) || !(rg inside {4'h0, 4'h8, 4'hE, 4'hF}));
    if (m_fault && wr && rg == 4'hF && off == 5) m_fault = 0;
    else if (!m_fault && bad) begin m_fault = 1; m_faddr = a; end
    if (console_ready && mq.size() > 0) void'(mq.pop_front());
    if (wr && rg == 4'h8) m_ram[wi] = lanes(m_ram.exists(wi) ? m_ram[wi] : 'x, wd, a[1:0], m);
    if (wr && rg == 4'hF) begin
      if (off == 0) begin
        if (wd[31] && m[3]) m_ovf = 0;
        if (m[0]) begin
          if (mq.size() < CD) mq.push_back(sh[7:0]);
          else m_ovf = 1;
        end
      end
      if (off == 2) begin m_test = lanes(m_test, wd, a[1:0], m); if (m_test != 0) m_done = 1; end
      if (off == 3) m_scr = lanes(m_scr, wd, a[1:0], m);
    end
    m_tick++;
  endtask
  task automatic step(input bit rd, wr, input logic [31:0] a, wd, input logic [3:0] m);
    bus_rden = rd; bus_wren = wr; bus_addr = a; bus_wdata = wd; bus_wmask = m;
    @(posedge clock);
    model(rd, wr, a, wd, m);
    #1;
    bus_rden = 0; bus_wren = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic assert_reset();
    in_reset = 1; reset_in = 1;
    clear_model();
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1 reset_in = 0; in_reset = 0;
  endtask
  // monitor: pops the expected read word whenever a read was issued, otherwise bus_rdata must hold
  always @(negedge clock) begin
    if (!in_reset) begin
      if (rd_fired) begin
        last_rd = exp_rd.pop_front();
        rd_fired = 0;
        chk("rdata", bus_rdata, last_rd);
      end else chk("rdata_hold", bus_rdata, last_rd);
      chk("console_valid", {31'b0, console_valid}, {31'b0, mq.size() != 0});
      if (console_valid && mq.size() > 0) chk("console_data", {24'b0, console_data}, {24'b0, mq[0]});
      chk("test_status", test_status, m_test);
      chk("test_done", {31'b0, test_done}, {31'b0, m_done});
`ifdef PINWHEEL_BUS_FAULT_EN
      chk("bus_fault", {31'b0, bus_fault}, {31'b0, m_fault});
`endif
    end
  end
  initial begin
    logic [31:0] a;
    int k;
    assert_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_console", {23'b0, console_valid, console_data}, 32'h0);
    chk("reset_test", {test_status[30:0], test_done}, 32'h0);
    reset_in = 0; in_reset = 0;
    step(0, 1, 32'h8000_0004, 32'h1122_3344, 4'hF);
    step(0, 1, 32'h8000_0005, 32'h0000_00AB, 4'b0010);
    step(1, 0, 32'h8000_0004, 32'h0, 4'h0);
    step(0, 1, 32'h8000_0006, 32'h0000_BEEF, 4'b1100);
    step(1, 0, 32'h8000_0004, 32'h0, 4'h0);
    idle(2);
    step(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF);
    step(1, 0, 32'h8000_0000 + 4*DW, 32'h0, 4'h0);
    idle(1);
    console_ready = 0;
    step(0, 1, 32'hF000_0000, 32'h48, 4'h1);
    step(0, 1, 32'hF000_0000, 32'h69, 4'h1);
    step(1, 0, 32'hF000_0000, 32'h0, 4'h0);
    console_ready = 1;
    idle(3);
    console_ready = 0;
    for (int i = 0; i < 9; i++) step(0, 1, 32'hF000_0000, 32'h30 + i, 4'h1);
    step(1, 0, 32'hF000_0000, 32'h0, 4'h0);
    console_ready = 1;
    step(0, 1, 32'hF000_0000, 32'h55, 4'h1);
    step(1, 0, 32'hF000_0000, 32'h0, 4'h0);
    idle(10);
    step(0, 1, 32'hF000_0000, 32'h8000_0000, 4'b1000);
    step(1, 0, 32'hF000_0000, 32'h0, 4'h0);
    step(0, 1, 32'hF000_0008, 32'h1, 4'hF);
    idle(1);
    step(0, 1, 32'hF000_0008, 32'h0, 4'hF);
    step(1, 0, 32'hF000_0004, 32'h0, 4'h0);
    idle(9);
    step(1, 0, 32'hF000_0004, 32'h0, 4'h0);
    step(0, 1, 32'hF000_000C, 32'h1234_5678, 4'hF);
    step(0, 1, 32'hF000_000E, 32'h0000_00AA, 4'b0100);
    step(1, 0, 32'hF000_000C, 32'h0, 4'h0);
    step(1, 0, 32'h3000_0000, 32'h0, 4'h0);
    step(1, 0, 32'hE000_0000, 32'h0, 4'h0);
    step(1, 0, 32'hF000_0018, 32'h0, 4'h0);
    console_ready = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 32'hF000_0000, 32'h61 + i, 4'h1);
    console_ready = 1;
    step(1, 0, 32'h8000_0000, 32'h0, 4'h0);
    #1 assert_reset();
    #1;
    chk("midreset_valid", {31'b0, console_valid}, 32'h0);
    chk("midreset_rdata", bus_rdata, 32'h0);
    release_reset();
    step(1, 0, 32'h8000_0004, 32'h0, 4'h0);
`ifdef PINWHEEL_BUS_FAULT_EN
    step(0, 1, 32'hF000_0014, 32'h0, 4'hF);
    step(1, 0, 32'h3000_0000, 32'h0, 4'h0);
    step(1, 0, 32'hF000_0010, 32'h0, 4'h0);
    step(0, 1, 32'hF000_0014, 32'h0, 4'hF);
`endif
    for (int w = 0; w < 16; w++) step(0, 1, 32'h8000_0000 | (w << 2), $urandom, 4'hF);
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      console_ready = 1'($urandom_range(0, 1));
      a = 32'h8000_0000 | ($urandom_range(0, 4095) << 16) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      case (k)
        0, 1: step(0, 1, a, $urandom, 4'($urandom_range(0, 15)));
        2:    step(1, 1, a, $urandom, 4'($urandom_range(0, 15)));
        3, 4: step(1, 0, a, 32'h0, 4'h0);
        5:    step(0, 1, 32'hF000_0000 | ($urandom_range(0, 'hFFFFF) << 8) | $urandom_range(0, 3),
                   $urandom & 32'h7FFF_FFFF, 4'($urandom_range(0, 15)));
        6:    step(1, 0, 32'hF000_0000 | ($urandom_range(0, 15) << 2), 32'h0, 4'h0);
        7:    step(0, 1, 32'hF000_0008 | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3),
                   $urandom, 4'($urandom_range(0, 15)));
        8: begin
          case ($urandom_range(0, 3))
            0: a = 32'h0000_0000;
            1: a = 32'h3000_0000;
            2: a = 32'h5000_0010;
            default: a = 32'hE000_0004;
          endcase
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 4'hF);
        end
        default: step(0, 1, 32'hF000_0000, 32'h8000_0000, 4'b1000);
      endcase
    end
    idle(12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
